// File: rtl/tg68k_fpu_movem_if.sv
// Bus and register-file strobe bundle for the FMOVEM sequencer.
// The master side is the sequencer; the slave side is memory plus responder.
interface tg68k_fpu_movem_seq_if;
    logic        fmovem_data_request;
    logic        fmovem_data_write;
    logic [2:0]  fmovem_reg_index;
    logic [79:0] fmovem_data_out;
    logic [79:0] fmovem_data_in;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output fmovem_data_request,
        output fmovem_data_write,
        output fmovem_reg_index,
        output fmovem_data_out,
        input  fmovem_data_in,
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  fmovem_data_request,
        input  fmovem_data_write,
        input  fmovem_reg_index,
        input  fmovem_data_out,
        output fmovem_data_in,
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/tg68k_fpu_movem_seq.sv
// FMOVEM initiator: walks the FP register mask and moves each extended
// value to or from memory as three longword beats (96-bit layout).
module tg68k_fpu_movem_seq (
    input  logic                          clk,
    input  logic                          nReset,
    input  logic                          clkena,
    input  logic                          start_i,
    input  logic                          direction_i,
    input  logic [7:0]                    register_mask_i,
    input  logic                          predecrement_i,
    input  logic [31:0]                   base_addr_i,
    tg68k_fpu_movem_seq_if.master         fm,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          addr_error_o,
    output logic [31:0]                   final_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_REGRD,
        S_REGWAIT,
        S_BUS,
        S_REGWR,
        S_DONE
    } state_t;

    state_t      state_q;
    logic        dir_q;
    logic        pre_q;
    logic [7:0]  pend_q;
    logic [31:0] addr_q;
    logic [31:0] cur_q;
    logic [1:0]  beat_q;
    logic [79:0] hold_q;
    logic [2:0]  idx_q;
    logic        req_q;
    logic        wr_q;
    logic [79:0] dout_q;
    logic        breq_q;
    logic        bwe_q;
    logic [31:0] baddr_q;
    logic [31:0] bwdata_q;
    logic        busy_q;
    logic        done_q;
    logic        aerr_q;
    logic [31:0] final_q;

    logic        found_d;
    logic [2:0]  sel_d;
    logic [7:0]  rev_d;
    logic [31:0] cur_d;

    // pend_q is indexed by FP register number regardless of mask order.
    always_comb begin
        found_d = |pend_q;
        sel_d   = 3'd0;
        rev_d   = 8'd0;
        for (int i = 0; i < 8; i++) begin
            rev_d[i] = register_mask_i[7-i];
            if (pre_q) begin
                if (pend_q[i]) sel_d = 3'(i);
            end else begin
                if (pend_q[7-i]) sel_d = 3'(7-i);
            end
        end
        cur_d = pre_q ? addr_q - 32'd12 : addr_q;
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            pre_q    <= 1'b0;
            pend_q   <= 8'd0;
            addr_q   <= 32'd0;
            cur_q    <= 32'd0;
            beat_q   <= 2'd0;
            hold_q   <= 80'd0;
            idx_q    <= 3'd0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            dout_q   <= 80'd0;
            breq_q   <= 1'b0;
            bwe_q    <= 1'b0;
            baddr_q  <= 32'd0;
            bwdata_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            aerr_q   <= 1'b0;
            final_q  <= 32'd0;
        end else if (clkena) begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    aerr_q <= 1'b0;
                    if (start_i) begin
                        state_q <= S_SCAN;
                        busy_q  <= 1'b1;
                        dir_q   <= direction_i;
                        pre_q   <= predecrement_i;
                        pend_q  <= predecrement_i ? register_mask_i : rev_d;
                        addr_q  <= base_addr_i;
                    end
                end
                S_SCAN: begin
                    if (addr_q[0] || !found_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        aerr_q  <= addr_q[0];
                        final_q <= addr_q;
                    end else begin
                        idx_q  <= sel_d;
                        cur_q  <= cur_d;
                        beat_q <= 2'd0;
                        if (dir_q) begin
                            state_q <= S_REGRD;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= S_BUS;
                            breq_q  <= 1'b1;
                            bwe_q   <= 1'b0;
                            baddr_q <= cur_d;
                        end
                    end
                end
                S_REGRD: begin
                    req_q   <= 1'b0;
                    state_q <= S_REGWAIT;
                end
                S_REGWAIT: begin
                    hold_q   <= fm.fmovem_data_in;
                    breq_q   <= 1'b1;
                    bwe_q    <= 1'b1;
                    baddr_q  <= cur_q;
                    bwdata_q <= {fm.fmovem_data_in[79:64], 16'h0000};
                    state_q  <= S_BUS;
                end
                S_BUS: begin
                    if (fm.bus_ack) begin
                        beat_q <= beat_q + 2'd1;
                        if (!dir_q && beat_q == 2'd0)
                            hold_q[79:64] <= fm.bus_rdata[31:16];
                        if (!dir_q && beat_q == 2'd1)
                            hold_q[63:32] <= fm.bus_rdata;
                        if (beat_q == 2'd2) begin
                            breq_q        <= 1'b0;
                            bwe_q         <= 1'b0;
                            pend_q[idx_q] <= 1'b0;
                            addr_q        <= pre_q ? cur_q : cur_q + 32'd12;
                            if (dir_q) begin
                                state_q <= S_SCAN;
                            end else begin
                                state_q <= S_REGWR;
                                wr_q    <= 1'b1;
                                dout_q  <= {hold_q[79:32], fm.bus_rdata};
                            end
                        end else begin
                            baddr_q  <= baddr_q + 32'd4;
                            bwdata_q <= (beat_q == 2'd0) ? hold_q[63:32]
                                                         : hold_q[31:0];
                        end
                    end
                end
                S_REGWR: begin
                    wr_q    <= 1'b0;
                    state_q <= S_SCAN;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    aerr_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fm.fmovem_data_request = req_q;
    assign fm.fmovem_data_write   = wr_q;
    assign fm.fmovem_reg_index    = idx_q;
    assign fm.fmovem_data_out     = dout_q;
    assign fm.bus_req             = breq_q;
    assign fm.bus_we              = bwe_q;
    assign fm.bus_addr            = baddr_q;
    assign fm.bus_wdata           = bwdata_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign addr_error_o           = aerr_q;
    assign final_addr_o           = final_q;

endmodule

// File: tb/tb_tg68k_fpu_movem_seq.sv
// Bench for tg68k_fpu_movem_seq: memory + register-file responder,
// transaction-level reference model, directed and random transfers.
module tb_tg68k_fpu_movem_seq;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
    } beat_t;

    typedef struct {
        logic [2:0]  i;
        logic [79:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        clkena = 1'b1;
    logic        start = 1'b0;
    logic        direction = 1'b0;
    logic [7:0]  mask = 8'd0;
    logic        predec = 1'b0;
    logic [31:0] base = 32'd0;
    logic        busy, done, aerr;
    logic [31:0] final_addr;

    tg68k_fpu_movem_seq_if tif ();

    tg68k_fpu_movem_seq dut (
        .clk             (clk),
        .nReset          (nReset),
        .clkena          (clkena),
        .start_i         (start),
        .direction_i     (direction),
        .register_mask_i (mask),
        .predecrement_i  (predec),
        .base_addr_i     (base),
        .fm              (tif),
        .busy_o          (busy),
        .done_o          (done),
        .addr_error_o    (aerr),
        .final_addr_o    (final_addr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:4095];
    logic [79:0] fpr [0:7];
    int          waits = 0;
    logic        toggle = 1'b0;
    int          wcnt = 0;

    beat_t got_beats[$];
    wr_t   got_wr[$];
    beat_t exp_beats[$];
    wr_t   exp_wr[$];
    logic [31:0] exp_final;
    logic        exp_aerr;
    int          exp_n;
    int          done_cnt = 0;
    int          overlap = 0;
    int          stab_err = 0;
    logic        h_valid = 1'b0;
    logic [64:0] h_val;

    assign tif.bus_ack   = tif.bus_req && (wcnt >= waits);
    assign tif.bus_rdata = mem[tif.bus_addr[13:2]];

    always @(negedge clk) clkena = toggle ? ~clkena : 1'b1;

    // Responder, memory and monitor; all act on enabled edges only.
    always @(posedge clk) begin
        if (!nReset) begin
            wcnt    <= 0;
            h_valid = 1'b0;
        end else if (clkena) begin
            if (done) done_cnt++;
            if (tif.fmovem_data_request && tif.fmovem_data_write) overlap++;
            if (tif.fmovem_data_request)
                tif.fmovem_data_in <= fpr[tif.fmovem_reg_index];
            if (tif.fmovem_data_write) begin
                got_wr.push_back('{tif.fmovem_reg_index, tif.fmovem_data_out});
                fpr[tif.fmovem_reg_index] <= tif.fmovem_data_out;
            end
            if (tif.bus_req) begin
                if (h_valid && h_val !== {tif.bus_addr, tif.bus_we, tif.bus_wdata})
                    stab_err++;
                if (tif.bus_ack) begin
                    got_beats.push_back('{tif.bus_addr, tif.bus_we,
                                          tif.bus_we ? tif.bus_wdata : 32'd0});
                    if (tif.bus_we) mem[tif.bus_addr[13:2]] <= tif.bus_wdata;
                    wcnt    <= 0;
                    h_valid = 1'b0;
                end else begin
                    wcnt    <= wcnt + 1;
                    h_valid = 1'b1;
                    h_val   = {tif.bus_addr, tif.bus_we, tif.bus_wdata};
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".bus_req"}, 80'(tif.bus_req), 80'd0);
        chk({tag, ".bus_we"}, 80'(tif.bus_we), 80'd0);
        chk({tag, ".bus_addr"}, 80'(tif.bus_addr), 80'd0);
        chk({tag, ".bus_wdata"}, 80'(tif.bus_wdata), 80'd0);
        chk({tag, ".req"}, 80'(tif.fmovem_data_request), 80'd0);
        chk({tag, ".wr"}, 80'(tif.fmovem_data_write), 80'd0);
        chk({tag, ".idx"}, 80'(tif.fmovem_reg_index), 80'd0);
        chk({tag, ".dout"}, tif.fmovem_data_out, 80'd0);
        chk({tag, ".busy"}, 80'(busy), 80'd0);
        chk({tag, ".done"}, 80'(done), 80'd0);
        chk({tag, ".aerr"}, 80'(aerr), 80'd0);
        chk({tag, ".final"}, 80'(final_addr), 80'd0);
    endtask

    // Reference: list of beats and register writes straight from the rules.
    task automatic model(input logic [7:0] m, input logic d, input logic p,
                         input logic [31:0] b);
        logic [31:0] a, ra;
        int n;
        logic sel;
        exp_beats.delete();
        exp_wr.delete();
        exp_final = b;
        exp_aerr  = b[0];
        exp_n     = 0;
        if (b[0]) return;
        a = b;
        for (int k = 0; k < 8; k++) begin
            n   = p ? 7 - k : k;
            sel = p ? m[n] : m[7-n];
            if (sel) begin
                ra = p ? a - 32'd12 : a;
                if (d) begin
                    exp_beats.push_back('{ra, 1'b1, {fpr[n][79:64], 16'h0000}});
                    exp_beats.push_back('{ra + 32'd4, 1'b1, fpr[n][63:32]});
                    exp_beats.push_back('{ra + 32'd8, 1'b1, fpr[n][31:0]});
                end else begin
                    exp_beats.push_back('{ra, 1'b0, 32'd0});
                    exp_beats.push_back('{ra + 32'd4, 1'b0, 32'd0});
                    exp_beats.push_back('{ra + 32'd8, 1'b0, 32'd0});
                    exp_wr.push_back('{3'(n), {mem[ra[13:2]][31:16],
                        mem[(ra + 32'd4) >> 2 & 32'hFFF],
                        mem[(ra + 32'd8) >> 2 & 32'hFFF]}});
                end
                a = p ? ra : ra + 32'd12;
                exp_n++;
            end
        end
        exp_final = a;
    endtask

    task automatic issue_start(input logic [7:0] m, input logic d,
                               input logic p, input logic [31:0] b);
        @(negedge clk);
        mask = m; direction = d; predec = p; base = b;
        start = 1'b1;
        do @(posedge clk); while (!clkena);
        #1 start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] m, input logic d,
                       input logic p, input logic [31:0] b);
        int k;
        logic seen;
        int exp_lat;
        @(negedge clk);
        model(m, d, p, b);
        got_beats.delete();
        got_wr.delete();
        done_cnt = 0;
        overlap  = 0;
        stab_err = 0;
        issue_start(m, d, p, b);
        k = 0;
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(posedge clk);
            if (clkena) k++;
            #1 seen = done;
        end
        chk({tag, ".done_seen"}, 80'(seen), 80'd1);
        chk({tag, ".aerr"}, 80'(aerr), 80'(exp_aerr));
        chk({tag, ".final"}, 80'(final_addr), 80'(exp_final));
        exp_lat = exp_n * ((d ? 3 : 2) + 3 * (waits + 1)) + 1;
        chk({tag, ".latency"}, 80'(k), 80'(exp_lat));
        repeat (4) @(posedge clk);
        #1;
        chk({tag, ".done_cnt"}, 80'(done_cnt), 80'd1);
        chk({tag, ".busy_after"}, 80'(busy), 80'd0);
        chk({tag, ".overlap"}, 80'(overlap), 80'd0);
        chk({tag, ".stable"}, 80'(stab_err), 80'd0);
        chk({tag, ".n_beats"}, 80'(got_beats.size()), 80'(exp_beats.size()));
        chk({tag, ".n_wr"}, 80'(got_wr.size()), 80'(exp_wr.size()));
        if (got_beats.size() == exp_beats.size())
            foreach (exp_beats[i])
                chk({tag, ".beat"},
                    80'({got_beats[i].a, got_beats[i].we, got_beats[i].d}),
                    80'({exp_beats[i].a, exp_beats[i].we, exp_beats[i].d}));
        if (got_wr.size() == exp_wr.size())
            foreach (exp_wr[i])
                chk({tag, ".wr"}, {got_wr[i].d[76:0], got_wr[i].i},
                    {exp_wr[i].d[76:0], exp_wr[i].i});
    endtask

    initial begin
        logic [95:0] t;
        logic [31:0] b;
        int cyc;
        for (int i = 0; i < 4096; i++) mem[i] <= $urandom;
        for (int i = 0; i < 8; i++) begin
            t = {$urandom, $urandom, $urandom};
            fpr[i] <= t[79:0];
        end
        fpr[0] <= 80'h3FFF_8000000000000000;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) nReset = 1'b1;

        run("store81", 8'h81, 1'b1, 1'b0, 32'h1000);
        chk("store81.b0", 80'({got_beats[0].a, got_beats[0].d}),
            80'({32'h1000, 32'h3FFF0000}));
        chk("store81.b1", 80'(got_beats[1].d), 80'h80000000);
        chk("store81.b3a", 80'(got_beats[3].a), 80'h100C);
        chk("store81.fin", 80'(final_addr), 80'h1018);

        run("predec01", 8'h01, 1'b1, 1'b1, 32'h2000);
        chk("predec01.b0a", 80'(got_beats[0].a), 80'h1FF4);
        chk("predec01.b2a", 80'(got_beats[2].a), 80'h1FFC);
        chk("predec01.fin", 80'(final_addr), 80'h1FF4);

        mem[12'hC00] <= 32'hC000ABCD;
        mem[12'hC01] <= 32'h12345678;
        mem[12'hC02] <= 32'h9ABCDEF0;
        run("load40", 8'h40, 1'b0, 1'b0, 32'h3000);
        chk("load40.idx", 80'(got_wr[0].i), 80'd1);
        chk("load40.data", got_wr[0].d, 80'hC000_123456789ABCDEF0);

        run("empty", 8'h00, 1'b1, 1'b0, 32'h1000);
        run("odd", 8'hFF, 1'b1, 1'b0, 32'h1001);
        chk("odd.aerr_fin", 80'(final_addr), 80'h1001);

        waits = 3;
        toggle = 1'b1;
        run("slow_store", 8'h81, 1'b1, 1'b0, 32'h1000);
        run("slow_load", 8'h5A, 1'b0, 1'b1, 32'h0800);
        toggle = 1'b0;

        // Reset during beat 1 of a load.
        got_beats.delete();
        got_wr.delete();
        issue_start(8'h40, 1'b0, 1'b0, 32'h3000);
        cyc = 0;
        while (got_beats.size() < 1 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        chk("rst.beat0_seen", 80'(got_beats.size()), 80'd1);
        @(negedge clk);
        chk("rst.in_beat1", 80'(tif.bus_req), 80'd1);
        nReset = 1'b0;
        @(posedge clk);
        #1 chk_reset_outputs("midrst");
        chk("midrst.no_wr", 80'(got_wr.size()), 80'd0);
        @(negedge clk) nReset = 1'b1;
        waits = 0;
        run("restart", 8'h40, 1'b0, 1'b0, 32'h3000);

        for (int r = 0; r < 20; r++) begin
            b = $urandom;
            b[0] = ($urandom_range(0, 9) == 0);
            waits  = $urandom_range(0, 2);
            toggle = ($urandom_range(0, 3) == 0);
            run("rand", 8'($urandom), 1'($urandom), 1'($urandom), b);
        end
        toggle = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tg68k_fpu_movem_seq.md
# tg68k_fpu_movem_seq

Initiator side of the FPU FMOVEM register-transfer interface. Walks an 8-bit FP register mask and drives the register-file responder's `fmovem_data_request` / `fmovem_data_write` / `fmovem_reg_index` strobes. It moves each 80-bit extended value to or from memory as three longword bus beats, using the 96-bit memory layout. It sits between the TG68K FPU decode/EA logic and the FPU MOVEM responder, and it reports the final address so the EA logic can write back An.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `nReset` in 1: reset, synchronous, active-low.
- `clkena` in 1: core clock enable. State, counters and strobes advance only when it is 1.
- `start` in 1: begin a transfer. Sampled only in IDLE.
- `direction` in 1: 0 = memory→FP registers; 1 = FP registers→memory.
- `register_mask` in 8: FP register list.
- `predecrement` in 1: 1 = -(An) mode; 0 = control/(An)+ mode.
- `base_addr` in 32: An or EA at start.
- `fmovem_data_request` out 1: read strobe to the responder.
- `fmovem_data_write` out 1: write strobe to the responder.
- `fmovem_reg_index` out 3: FP register number.
- `fmovem_data_out` out 80: write data to the responder.
- `fmovem_data_in` in 80: read data from the responder. Valid on the clkena cycle after the request.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_wdata` out 32: longword bus request.
- `bus_rdata` in 32, `bus_ack` in 1: bus response. `bus_ack` is sampled only when `clkena`=1.
- `busy` out 1, `done` out 1 (1-cycle pulse), `addr_error` out 1 (pulse, coincident with `done`), `final_addr` out 32.

## Operation
- Mask mapping:
  - predecrement=0: bit7=FP0 … bit0=FP7. Registers are processed in ascending order FP0→FP7. Addresses start at base and increase by 12 per register.
  - predecrement=1: bit7=FP7 … bit0=FP0. Registers are processed in descending order FP7→FP0. The first register goes at base-12, then addresses decrease by 12 per register.
- Within one register, the three beats are always at a, a+4, a+8:
  - beat0 = {data[79:64], 16'h0000}
  - beat1 = data[63:32]
  - beat2 = data[31:0]
  - On reads, bits [15:0] of beat0 are ignored.
- `final_addr` = base ± 12·popcount(mask). It is valid from `done` until the next start.
- States: IDLE, SCAN, REGRD, REGWAIT, BUS, REGWR, DONE.
  - IDLE → SCAN on `start`. `busy`=1 from then until DONE.
  - SCAN: selects the next set mask bit in processing order.
    - No bit left → DONE.
    - direction=1 → REGRD.
    - direction=0 → BUS.
  - REGRD: asserts `fmovem_data_request` for one clkena cycle with the index. → REGWAIT.
  - REGWAIT: captures `fmovem_data_in` into the 80-bit holding register. → BUS.
  - BUS: issues beats 0..2. `bus_req` and address/data are held stable until `bus_ack`; the beat counter increments on each ack.
    - After beat 2, direction=1 → SCAN. The address advances and the mask bit is cleared.
    - After beat 2, direction=0 → REGWR. Read beats are assembled into the holding register.
  - REGWR: asserts `fmovem_data_write` for one clkena cycle with index and data. → SCAN.
  - DONE: `done`=1 and `busy`=0 for one clkena cycle. → IDLE.
- Empty mask: SCAN → DONE. No bus or register strobes occur, and `final_addr` = base.
- Odd `base_addr[0]`: SCAN → DONE with `addr_error`=1. No strobes occur, and `final_addr` = base.
- `start` while busy is ignored.

## Timing
- Reset values:
  - All strobes = 0: `bus_req`, `bus_we`, `fmovem_data_request`, `fmovem_data_write`, `busy`, `done`, `addr_error`.
  - All buses = 0: `fmovem_reg_index`, `fmovem_data_out`, `bus_addr`, `bus_wdata`, `final_addr`.
  - State = IDLE.
- `nReset` low mid-transfer: next edge returns to IDLE with all outputs at reset values. A write strobe must not be emitted on that edge.
- `clkena`=0 freezes all registers. Strobes stay at their current level and are counted as active for only one enabled cycle.
- Per-register latency, zero-wait bus (ack on the first enabled cycle):
  - direction=1: SCAN 1 + REGRD 1 + REGWAIT 1 + 3 beats = 6 clkena cycles.
  - direction=0: SCAN 1 + 3 beats + REGWR 1 = 5 clkena cycles.
  - Plus DONE 1.
- `bus_we` = direction throughout BUS.
- `fmovem_data_request` and `fmovem_data_write` are never high together.

## Test plan
- Control-mode store: mask=8'h81, direction=1, predec=0, base=32'h1000; FP0=80'h3FFF_8000000000000000; zero-wait bus.
  - Expect writes to 1000/1004/1008 = 3FFF0000/80000000/00000000, then FP7 at 100C..1014.
  - Expect `final_addr`=32'h1018 and one `done` pulse.
- Predecrement store: mask=8'h01 (FP0), base=32'h2000.
  - Expect beats at 1FF4, 1FF8, 1FFC and `final_addr`=32'h1FF4.
- Load: direction=0, mask=8'h40 (FP1), memory returns C000ABCD/12345678/9ABCDEF0.
  - Expect one `fmovem_data_write` with index 1 and data 80'hC000_123456789ABCDEF0.
- Empty mask, and separately base=32'h1001.
  - Expect `done` within 2 clkena cycles, no `bus_req`, and `addr_error`=1 only in the odd-base case.
- Bus ack delayed 3 cycles and `clkena` toggled every other cycle.
  - Expect address/data stable until ack and the same beat sequence as the zero-wait case.
- `nReset` asserted during beat 1 of a load.
  - Expect all outputs 0 on the next edge, no `fmovem_data_write`, and a clean restart on the next `start`.
